// File: rtl/usart_engine.sv
// rtl/usart_engine.sv - full-duplex UART with command port, TX FIFO and RX holding register
// Define USART_PARITY_EN to add a parity bit to both TX and RX frames.
module usart_engine #(
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int TX_DEPTH    = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 138
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic [2:0]           cmd_in,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 read,
    input  logic                 rx_pin,
    output logic                 tx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 tx_full,
    output logic                 tx_busy,
    output logic [3:0]           status
);

`ifdef USART_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int AW = $clog2(TX_DEPTH);
    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO      = DIV_W'(2);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(TX_DEPTH);
    localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BRK} rx_state_t;

    logic                 tx_en, rx_en, parity_odd;
    logic [DIV_W-1:0]     div_reg, div_next, div_eff;
    logic [7:0]           op;
    logic                 wr_ctrl, push, push_ok, tx_pop, clr_err;
    logic [DATA_BITS-1:0] fifo_mem [TX_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          fifo_cnt, cnt_next;

    tx_state_t            tx_st, tx_nxt;
    logic [DIV_W-1:0]     tx_cnt, tx_div;
    logic [3:0]           tx_bit;
    logic                 tx_stop, tx_par, tx_tick;
    logic [DATA_BITS-1:0] tx_shr;

    rx_state_t            rx_st, rx_nxt;
    logic                 rx_s1, rx_s2, rx_prev, rx_fall, rx_tick, rx_pbit;
    logic [DIV_W-1:0]     rx_cnt, rx_div;
    logic [3:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shr;
    logic                 stop_ok, frm_set, par_set, deliver, ovr_set, ovf_set;

    assign op      = 8'(data_in);
    assign wr_ctrl = write && (cmd_in == 3'd1);
    assign push    = write && (cmd_in == 3'd2);
    assign clr_err = wr_ctrl && data_in[2];
    assign div_eff = (div_reg < TWO) ? TWO : div_reg;

    always_comb begin
        div_next = div_reg;
        for (int i = 0; i < 8; i++) begin
            if (write && cmd_in == 3'd3 && i < DIV_W) div_next[i] = op[i];
            if (write && cmd_in == 3'd4 && i + 8 < DIV_W) div_next[i+8] = op[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_en      <= 1'b1;
            rx_en      <= 1'b1;
            parity_odd <= 1'b0;
            div_reg    <= DIV_W'(DEFAULT_DIV);
        end else begin
            div_reg <= div_next;
            if (wr_ctrl) begin
                tx_en      <= data_in[0];
                rx_en      <= data_in[1];
                parity_odd <= data_in[3];
            end
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (fifo_cnt != FULL_CNT || tx_pop);
    assign ovf_set = push && !push_ok;

    always_comb begin
        cnt_next = fifo_cnt;
        if (push_ok && !tx_pop) cnt_next = fifo_cnt + 1'b1;
        else if (!push_ok && tx_pop) cnt_next = fifo_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            tx_full  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= cnt_next;
            tx_full  <= (cnt_next == FULL_CNT);
        end
    end

    assign tx_tick = (tx_cnt == '0);
    assign tx_busy = (fifo_cnt != '0) || (tx_st != T_IDLE);

    always_comb begin
        tx_nxt = tx_st;
        tx_pop = 1'b0;
        case (tx_st)
            T_IDLE:  if (tx_en && fifo_cnt != '0) begin
                         tx_pop = 1'b1;
                         tx_nxt = T_START;
                     end
            T_START: if (tx_tick) tx_nxt = T_DATA;
            T_DATA:  if (tx_tick && tx_bit == LAST_BIT) tx_nxt = PARITY_EN ? T_PAR : T_STOP;
            T_PAR:   if (tx_tick) tx_nxt = T_STOP;
            T_STOP:  if (tx_tick && tx_stop == STOP_LAST) begin
                         if (tx_en && fifo_cnt != '0) begin
                             tx_pop = 1'b1;
                             tx_nxt = T_START;
                         end else begin
                             tx_nxt = T_IDLE;
                         end
                     end
            default: tx_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_st   <= T_IDLE;
            tx_pin  <= 1'b1;
            tx_cnt  <= '0;
            tx_div  <= TWO;
            tx_bit  <= '0;
            tx_stop <= 1'b0;
            tx_par  <= 1'b0;
            tx_shr  <= '0;
        end else begin
            tx_st <= tx_nxt;
            if (tx_pop) begin
                tx_shr  <= fifo_mem[rd_ptr];
                tx_par  <= (^fifo_mem[rd_ptr]) ^ parity_odd;
                tx_div  <= div_eff;
                tx_cnt  <= div_eff - ONE;
                tx_pin  <= 1'b0;
                tx_bit  <= '0;
                tx_stop <= 1'b0;
            end else if (tx_st != T_IDLE) begin
                if (!tx_tick) begin
                    tx_cnt <= tx_cnt - ONE;
                end else begin
                    tx_cnt <= tx_div - ONE;
                    case (tx_st)
                        T_START: tx_pin <= tx_shr[0];
                        T_DATA: begin
                            if (tx_bit == LAST_BIT) begin
                                tx_pin <= PARITY_EN ? tx_par : 1'b1;
                            end else begin
                                tx_bit <= tx_bit + 4'd1;
                                tx_shr <= tx_shr >> 1;
                                tx_pin <= tx_shr[1];
                            end
                        end
                        T_PAR:  tx_pin <= 1'b1;
                        T_STOP: begin
                            tx_stop <= tx_stop + 1'b1;
                            tx_pin  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign rx_fall = rx_prev && !rx_s2;
    assign rx_tick = (rx_cnt == '0);
    assign stop_ok = (rx_st == R_STOP) && rx_tick && rx_s2;
    assign frm_set = (rx_st == R_STOP) && rx_tick && !rx_s2;
    assign par_set = PARITY_EN && stop_ok && (((^rx_shr) ^ rx_pbit) != parity_odd);
    assign deliver = stop_ok && !par_set;
    assign ovr_set = deliver && rx_valid && !read;

    always_comb begin
        rx_nxt = rx_st;
        case (rx_st)
            R_IDLE:  if (rx_en && rx_fall) rx_nxt = R_START;
            R_START: if (rx_tick) rx_nxt = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (rx_tick && rx_bit == LAST_BIT) rx_nxt = PARITY_EN ? R_PAR : R_STOP;
            R_PAR:   if (rx_tick) rx_nxt = R_STOP;
            R_STOP:  if (rx_tick) rx_nxt = rx_s2 ? R_IDLE : R_BRK;
            R_BRK:   if (rx_s2) rx_nxt = R_IDLE;
            default: rx_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_st    <= R_IDLE;
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_cnt   <= '0;
            rx_div   <= TWO;
            rx_bit   <= '0;
            rx_shr   <= '0;
            rx_pbit  <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            status   <= '0;
        end else begin
            rx_st   <= rx_nxt;
            rx_s1   <= rx_pin;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            // Divisor is re-latched every idle cycle, so it is frozen from the start edge on.
            if (rx_st == R_IDLE) begin
                rx_div <= div_eff;
                rx_cnt <= (div_eff >> 1) - ONE;
                rx_bit <= '0;
            end else if (!rx_tick) begin
                rx_cnt <= rx_cnt - ONE;
            end else begin
                rx_cnt <= rx_div - ONE;
                if (rx_st == R_DATA) begin
                    rx_shr <= {rx_s2, rx_shr[DATA_BITS-1:1]};
                    rx_bit <= rx_bit + 4'd1;
                end
                if (rx_st == R_PAR) rx_pbit <= rx_s2;
            end
            if (deliver && (!rx_valid || read)) begin
                rx_data  <= rx_shr;
                rx_valid <= 1'b1;
            end else if (read) begin
                rx_valid <= 1'b0;
            end
            if (clr_err) status <= '0;
            else         status <= status | {par_set, frm_set, ovr_set, ovf_set};
        end
    end

endmodule

// File: tb/tb_usart_engine.sv
// tb/tb_usart_engine.sv - directed testbench for usart_engine (DIV=4, TX_DEPTH=4)
module tb_usart_engine;
    logic       clk = 1'b0;
    logic       reset, write, read, rx_drv, loop;
    logic [2:0] cmd_in;
    logic [7:0] data_in;
    logic       rx_pin;
    logic       tx_pin, rx_valid, tx_full, tx_busy;
    logic [7:0] rx_data;
    logic [3:0] status;
    int         n_vec = 0;
    int         n_err = 0;

    assign rx_pin = loop ? tx_pin : rx_drv;

    usart_engine dut (
        .clk(clk), .reset(reset), .write(write), .cmd_in(cmd_in), .data_in(data_in),
        .read(read), .rx_pin(rx_pin), .tx_pin(tx_pin), .rx_data(rx_data),
        .rx_valid(rx_valid), .tx_full(tx_full), .tx_busy(tx_busy), .status(status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] c, input logic [7:0] d);
        write = 1'b1; cmd_in = c; data_in = d;
        tick();
        write = 1'b0; cmd_in = 3'd0; data_in = 8'h00;
    endtask

    task automatic do_read();
        read = 1'b1;
        tick();
        read = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (rx_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk(tag, rx_valid, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (tx_busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        chk(tag, tx_busy, 0);
    endtask

    task automatic bang(input logic [11:0] bits, input int nb);
        for (int i = 0; i < nb; i++) begin
            rx_drv = bits[i];
            repeat (4) tick();
        end
    endtask

    initial begin
        logic [9:0]  fr;
        logic [11:0] fb;
        logic        prev;
        int          falls;

        reset = 1'b1; write = 1'b0; read = 1'b0; cmd_in = 3'd0; data_in = 8'h00;
        rx_drv = 1'b1; loop = 1'b0;
        repeat (3) tick();
        chk("rst_tx_pin", tx_pin, 1);
        reset = 1'b0;
        tick();
        chk("rst_tx_pin_after", tx_pin, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_status", status, 0);

        // Single frame 0xA5 at DIV=4: start, LSB-first data, stop.
        cmd(3'd3, 8'd4);
        cmd(3'd4, 8'd0);
        fr = {1'b1, 8'hA5, 1'b0};
        cmd(3'd2, 8'hA5);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk($sformatf("a5_slot%0d_clk%0d", i / 4, i % 4), tx_pin, fr[i / 4]);
            if (i == 20) chk("a5_busy_mid", tx_busy, 1);
        end
        tick();
        chk("a5_busy_after", tx_busy, 0);
        chk("a5_idle_pin", tx_pin, 1);

        // Loopback, two back-to-back frames, each read before the next arrives.
        loop = 1'b1;
        cmd(3'd2, 8'h3C);
        cmd(3'd2, 8'hC3);
        wait_valid("lb1_valid");
        chk("lb1_data", rx_data, 8'h3C);
        do_read();
        chk("lb1_cleared", rx_valid, 0);
        wait_valid("lb2_valid");
        chk("lb2_data", rx_data, 8'hC3);
        do_read();
        wait_idle("lb_tx_idle");
        repeat (10) tick();
        chk("lb_status", status, 0);
        chk("lb_rx_valid", rx_valid, 0);

        // FIFO fill with TX disabled, overflow, then exactly four frames.
        loop = 1'b0;
        cmd(3'd1, 8'b0010);
        for (int k = 1; k <= 6; k++) begin
            cmd(3'd2, 8'hFF);
            if (k == 3) chk("fifo_full_at3", tx_full, 0);
            if (k == 4) chk("fifo_full_at4", tx_full, 1);
        end
        chk("fifo_overflow", status, 4'b0001);
        chk("fifo_busy_held", tx_busy, 1);
        chk("fifo_pin_held", tx_pin, 1);
        cmd(3'd1, 8'b0011);
        falls = 0;
        prev  = tx_pin;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (prev && !tx_pin) falls++;
            prev = tx_pin;
        end
        chk("fifo_frames_sent", falls, 4);
        chk("fifo_busy_done", tx_busy, 0);
        chk("fifo_full_done", tx_full, 0);
        cmd(3'd1, 8'b0111);
        chk("fifo_clr_err", status, 0);

        // Loopback overrun: second word dropped, first kept.
        loop = 1'b1;
        cmd(3'd2, 8'h12);
        cmd(3'd2, 8'h34);
        wait_idle("ovr_tx_idle");
        repeat (10) tick();
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_data_kept", rx_data, 8'h12);
        chk("ovr_status", status, 4'b0010);
        cmd(3'd1, 8'b0111);
        chk("ovr_clr_err", status, 0);
        do_read();
        chk("ovr_read_clears", rx_valid, 0);

        // Framing error: 0x55 with stop bit 0.
        loop = 1'b0;
        rx_drv = 1'b1;
        repeat (4) tick();
        fb = {4'b0000, 8'h55, 1'b0} >> 1;
        fb = {3'b000, 1'b0, 8'h55};
        fb = {fb[10:0], 1'b0};
        bang(fb, 10);
        repeat (8) tick();
        rx_drv = 1'b1;
        repeat (10) tick();
        chk("frm_status", status, 4'b0100);
        chk("frm_no_valid", rx_valid, 0);
        cmd(3'd1, 8'b0111);
        chk("frm_clr_err", status, 0);

        // One-clock glitch is a false start.
        rx_drv = 1'b0;
        tick();
        rx_drv = 1'b1;
        repeat (20) tick();
        chk("glitch_status", status, 0);
        chk("glitch_no_valid", rx_valid, 0);

        // A clean frame after the glitch is still received.
        fb = {3'b000, 1'b1, 8'h5A};
        fb = {fb[10:0], 1'b0};
        bang(fb, 10);
        wait_valid("clean_valid");
        chk("clean_data", rx_data, 8'h5A);
        do_read();
        chk("clean_status", status, 0);

`ifdef USART_PARITY_EN
        // Odd parity of 0x01 is 0; a wrong parity bit on RX is flagged.
        cmd(3'd1, 8'b1011);
        cmd(3'd2, 8'h01);
        repeat (38) tick();
        chk("par_tx_bit", tx_pin, 0);
        wait_idle("par_tx_idle");
        fb = {2'b00, 1'b1, 1'b1, 8'h01};
        fb = {fb[10:0], 1'b0};
        bang(fb, 11);
        repeat (10) tick();
        chk("par_status", status, 4'b1000);
        chk("par_no_valid", rx_valid, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/usart_engine.md
Name: usart_engine

Overview:
- Parametrised full-duplex UART controller: command-register write port, programmable baud divisor, TX FIFO, single-entry RX holding register, sticky error status.
- Generalises the fixed-divisor, TX-only, single-byte serial controller: configurable data width, stop bits, FIFO depth, divisor, plus an RX path.
- Sits between the CPU bus command decoder and the board serial pins.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9); also the width of data_in/rx_data.
- STOP_BITS, 1, stop bits per frame (1 or 2).
- TX_DEPTH, 4, TX FIFO entries; power of two, >= 2.
- DIV_W, 16, baud divisor register width.
- DEFAULT_DIV, 138, divisor loaded at reset (clocks per bit).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- write  in  1  command strobe, one command per high cycle
- cmd_in  in  3  command: 0 NOP, 1 SET_CTRL, 2 SET_DATA, 3 SET_DIV_LO, 4 SET_DIV_HI; 5-7 ignored
- data_in  in  DATA_BITS  command operand
- read  in  1  pop strobe for rx_data
- rx_pin  in  1  serial input, asynchronous
- tx_pin  out  1  serial output, idle high
- rx_data  out  DATA_BITS  last received word
- rx_valid  out  1  rx_data unread
- tx_full  out  1  TX FIFO full
- tx_busy  out  1  FIFO non-empty or frame in progress
- status  out  4  {parity_err, frame_err, rx_overrun, tx_overflow}, sticky

Behaviour:
- Reset: tx_pin=1, rx_valid=0, rx_data=0, tx_full=0, tx_busy=0, status=0, FIFO empty, divisor=DEFAULT_DIV, ctrl tx_en=1, rx_en=1, parity_odd=0.
- SET_CTRL: bit0 tx_en; bit1 rx_en; bit2 clr_err (self-clearing, zeroes status next cycle); bit3 parity_odd.
- SET_DIV_LO/HI: write bits [7:0] / [15:8] of the divisor (DIV_W-bit register; bits above DIV_W dropped). Stored values <2 are used as 2.
- Each engine latches the divisor at frame start; mid-frame writes affect only the next frame.
- SET_DATA: push data_in into the TX FIFO.
  - Push while full is dropped and sets tx_overflow.
  - tx_full is registered and updates the cycle after a push/pop.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: if tx_en=1 and FIFO non-empty, pop the head and enter START the next cycle.
  - Each state holds tx_pin for exactly div clocks. START drives 0. DATA drives LSB first, DATA_BITS bits. STOP drives 1 for STOP_BITS*div clocks.
  - Latency: first start-bit clock is 2 cycles after the SET_DATA write on an idle engine.
  - Back-to-back frames carry no extra idle clocks.
  - Clearing tx_en mid-frame completes the current frame, then holds.
- RX path: 2-flop synchroniser on rx_pin.
  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP.
  - IDLE: when rx_en=1 and a synchronised falling edge is seen, wait div/2 (floor), then resample. Still high means false start; return to IDLE.
  - Then sample every div clocks: DATA_BITS bits LSB first, optional parity, first stop bit only.
  - Stop sampled 0: set frame_err, discard word, return to IDLE on the next high sample.
  - Valid frame: rx_data <= word and rx_valid <= 1 on the cycle after the stop sample.
  - If rx_valid is already 1: set rx_overrun, keep the old rx_data.
  - read with rx_valid=1 clears rx_valid the next cycle.
  - read and new-word delivery in the same cycle: new word loaded, rx_valid stays 1, no overrun.
- Simultaneous SET_DATA push and TX pop when full: pop wins the slot and the push succeeds.
- Reset mid-frame: tx_pin returns to 1 immediately (asynchronous); the frame is abandoned.
- tx_busy = FIFO non-empty OR TX FSM not IDLE.

Optional Feature:
- USART_PARITY_EN defined:
  - TX inserts the PARITY state after DATA: even parity if parity_odd=0, odd if 1.
  - RX checks the parity bit; mismatch sets parity_err and discards the word.
- Undefined:
  - No parity state; parity_odd is stored but has no effect.
  - parity_err is tied 0.

Test Plan:
- Reset, DIV set to 4 (SET_DIV_LO 4, SET_DIV_HI 0), SET_DATA 0xA5 -> tx_pin: 0 for 4 clks, then 1,0,1,0,0,1,0,1 (4 clks each), then 1 for 4 clks; tx_busy low after.
- Loopback tx_pin->rx_pin, DIV=4, send 0x3C then 0xC3 -> rx_valid pulses; read yields 0x3C then 0xC3; status=0.
- DIV=4, 6 SET_DATA writes with tx_en=0 and TX_DEPTH=4 -> tx_full=1 after the 4th write; tx_overflow set; enabling tx_en sends exactly 4 frames.
- Loopback, two frames with no read -> rx_data holds the first word; rx_overrun=1; SET_CTRL clr_err -> status=0.
- rx_pin driven with stop bit 0 (0x55 frame) -> frame_err=1, rx_valid stays 0; 1-clk low glitch on rx_pin -> no frame, no error.
- With USART_PARITY_EN, parity_odd=1, send 0x01 -> parity bit 0 on the wire; loopback with a flipped parity bit -> parity_err=1.
